// File: rtl/keypad_pkg.sv
// Shared types, key layout and row-pattern classification for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ROWS_IDLE   = 2'd0,
        ROWS_SINGLE = 2'd1,
        ROWS_MULTI  = 2'd2
    } rows_class_t;

    // Indexed by {row, col}; bottom row is * = E, 0, # = F, D.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic rows_class_t onehot_low(input logic [3:0] rows);
        rows_class_t cls;
        case (rows)
            4'hF:                   cls = ROWS_IDLE;
            4'hE, 4'hD, 4'hB, 4'h7: cls = ROWS_SINGLE;
            default:                cls = ROWS_MULTI;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'hD:    idx = 2'd1;
            4'hB:    idx = 2'd2;
            4'h7:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row inputs.
module keypad_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Cleared to the idle (all-high) pattern so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce and a one-clock key_valid strobe.
// Optional auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
//
//   state    | meaning
//   SCAN     | rotating the driven column, waiting for a single row low
//   DEBOUNCE | column frozen, row pattern must stay stable to accept
//   PRESSED  | key accepted and held; other keys ignored
//   RELEASE  | rows idle, must stay idle to drop the key
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("keypad_scan: parameter out of range");
    end

    logic [3:0]       w_rows_s;
    rows_class_t      w_class;
    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [DIV_W-1:0] r_div;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             w_row_match;
    logic             w_deb_done;
    logic             w_accept;
    logic             w_repeat;
    logic             w_strobe;
    logic             w_col_step;

    keypad_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rows),
        .o_q (w_rows_s)
    );

    assign w_class     = onehot_low(w_rows_s);
    assign w_row_match = (w_rows_s == ~(4'b0001 << r_row_idx));
    assign w_deb_done  = (r_deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCAN: begin
                if (w_class == ROWS_SINGLE) w_state_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!w_row_match)    w_state_next = SCAN;
                else if (w_deb_done) w_state_next = PRESSED;
            end
            PRESSED: begin
                if (w_class == ROWS_IDLE) w_state_next = RELEASE;
            end
            RELEASE: begin
                if (w_class != ROWS_IDLE) w_state_next = PRESSED;
                else if (w_deb_done)      w_state_next = SCAN;
            end
            default: w_state_next = SCAN;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == DEBOUNCE) && (w_state_next == PRESSED);
        w_strobe   = w_accept | w_repeat;
        w_col_step = ((r_state == DEBOUNCE || r_state == RELEASE) && w_state_next == SCAN) ||
                     (r_state == SCAN && w_state_next == SCAN && r_div == DIV_LAST);
        cols       = ~(4'b0001 << r_col_idx);
        key_held   = (r_state == PRESSED) || (r_state == RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_div       <= '0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_strobe;
            if (w_col_step) r_col_idx <= r_col_idx + 2'd1;
            // Divider only runs while idle-scanning so each column gets a full dwell.
            if (r_state == SCAN && w_state_next == SCAN && r_div != DIV_LAST)
                r_div <= r_div + 1'b1;
            else
                r_div <= '0;
            if (r_state == SCAN && w_state_next == DEBOUNCE) r_row_idx <= low_index(w_rows_s);
            if (w_state_next != r_state)
                r_deb_cnt <= '0;
            else if (r_deb_cnt != '1)
                r_deb_cnt <= r_deb_cnt + 1'b1;
            if (w_accept) r_key_code <= KEY_MAP[{r_row_idx, r_col_idx}];
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic             w_hold;

    assign w_hold   = (r_state == PRESSED) && (w_state_next == PRESSED);
    assign w_repeat = w_hold && (r_rpt_cnt == (r_rpt_first ? RPT_FIRST : RPT_NEXT));

    // Re-armed on every entry to PRESSED, including a bounce back from RELEASE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_state_next == PRESSED && r_state != PRESSED) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_repeat) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else if (r_rpt_cnt != '1) begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule
